// File: rtl/bmem_pkg.sv
// Shared state encoding and sizing helpers for the L2 line-to-burst adapter.
package bmem_pkg;

    localparam int BEAT_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_BEATS,
        ST_WR_BEATS,
        ST_WR_WAIT,
        ST_DONE
    } bmem_state_e;

    function automatic int burst_len(input int log2_wordsize);
        return 1 << (log2_wordsize - 6);
    endfunction

endpackage

// File: rtl/bmem_rr_arbiter.sv
// Two-requester round-robin grant (I-side vs D-side), priority pointer updated on completion.
// Latency: combinational grant; no backpressure, the caller samples the grant only while idle.
module bmem_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_done,
    input  logic i_served_d,
    output logic o_gnt_d
);

    // Priority goes to the side that was not served last; reset favours D.
    logic r_prio_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio_d <= 1'b1;
        end else if (i_done) begin
            r_prio_d <= ~i_served_d;
        end
    end

    assign o_gnt_d = i_req_d & (~i_req_i | r_prio_d);

endmodule

// File: rtl/bmem_line_adapter.sv
// Arbitrates I/D L2 line requests onto one burst port, (de)serialising lines into 64-bit beats; optional BMEM_LINE_ADAPTER_PERF_EN counters.
// Latency: read 1+1+BURST_LEN+1 cycles minimum, write BURST_LEN beats then one resp; read beats may stall via bmem_resp gaps.
module bmem_line_adapter
    import bmem_pkg::*;
#(
    parameter int CACHE_LOG2_WORDSIZE = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [31:0]                          i_addr,
    input  logic                                 i_read,
    output logic [(2**CACHE_LOG2_WORDSIZE)-1:0]  i_rdata,
    output logic                                 i_resp,
    input  logic [31:0]                          d_addr,
    input  logic                                 d_read,
    input  logic                                 d_write,
    input  logic [(2**CACHE_LOG2_WORDSIZE)-1:0]  d_wdata,
    output logic [(2**CACHE_LOG2_WORDSIZE)-1:0]  d_rdata,
    output logic                                 d_resp,
    output logic [31:0]                          bmem_address,
    output logic                                 bmem_read,
    output logic                                 bmem_write,
    output logic [BEAT_WIDTH-1:0]                bmem_wdata,
    input  logic [BEAT_WIDTH-1:0]                bmem_rdata,
    input  logic                                 bmem_resp
);

    localparam int LINE      = 2**CACHE_LOG2_WORDSIZE;
    localparam int BURST_LEN = burst_len(CACHE_LOG2_WORDSIZE);
    localparam int IDX_W     = $clog2(BURST_LEN);
    localparam int CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(BURST_LEN);
    localparam logic [31:0]      ADDR_MASK = ~((32'd1 << (CACHE_LOG2_WORDSIZE - 3)) - 32'd1);

    typedef logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] line_t;

    bmem_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] w_idx;
    logic             r_is_d, r_is_wr;
    line_t            r_buf, w_line_fill;
    logic [31:0]      r_addr;
    logic             r_bmem_read, r_bmem_write;
    logic [BEAT_WIDTH-1:0] r_bmem_wdata;
    logic [LINE-1:0]  r_i_rdata, r_d_rdata;
    logic             r_i_resp, r_d_resp;
    logic             w_req_d, w_any_req, w_gnt_d, w_gnt_wr, w_beat_acc, w_done;

    assign w_idx      = r_cnt[IDX_W-1:0];
    assign w_req_d    = d_read | d_write;
    assign w_any_req  = i_read | w_req_d;
    assign w_gnt_wr   = w_gnt_d & d_write;
    assign w_beat_acc = (r_state == ST_RD_BEATS) && bmem_resp && (r_cnt < CNT_END);
    assign w_done     = (r_state == ST_DONE);

    bmem_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_i    (i_read),
        .i_req_d    (w_req_d),
        .i_done     (w_done),
        .i_served_d (r_is_d),
        .o_gnt_d    (w_gnt_d)
    );

    // Shared line buffer with the current beat merged in, so the returned line
    // register is loaded complete on the last-beat edge.
    always_comb begin
        w_line_fill        = r_buf;
        w_line_fill[w_idx] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_any_req) w_state_nxt = w_gnt_wr ? ST_WR_BEATS : ST_RD_REQ;
            ST_RD_REQ:   w_state_nxt = ST_RD_BEATS;
            ST_RD_BEATS: if (w_beat_acc && (r_cnt == CNT_LAST)) w_state_nxt = ST_DONE;
            ST_WR_BEATS: if (r_cnt == CNT_END) w_state_nxt = ST_WR_WAIT;
            ST_WR_WAIT:  if (bmem_resp) w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_is_d       <= 1'b0;
            r_is_wr      <= 1'b0;
            r_buf        <= '0;
            r_addr       <= '0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            r_bmem_read <= 1'b0;
            r_i_resp    <= 1'b0;
            r_d_resp    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_is_d  <= w_gnt_d;
                        r_is_wr <= w_gnt_wr;
                        r_addr  <= (w_gnt_d ? d_addr : i_addr) & ADDR_MASK;
                        if (w_gnt_wr) begin
                            r_buf        <= d_wdata;
                            r_bmem_write <= 1'b1;
                            r_bmem_wdata <= d_wdata[BEAT_WIDTH-1:0];
                            r_cnt        <= CNT_W'(1);
                        end else begin
                            r_bmem_read <= 1'b1;
                            r_cnt       <= '0;
                        end
                    end
                end
                ST_RD_BEATS: begin
                    if (w_beat_acc) begin
                        r_buf[w_idx] <= bmem_rdata;
                        r_cnt        <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            if (r_is_d) begin
                                r_d_rdata <= w_line_fill;
                                r_d_resp  <= 1'b1;
                            end else begin
                                r_i_rdata <= w_line_fill;
                                r_i_resp  <= 1'b1;
                            end
                        end
                    end
                end
                ST_WR_BEATS: begin
                    if (r_cnt == CNT_END) begin
                        r_bmem_write <= 1'b0;
                    end else begin
                        r_bmem_wdata <= r_buf[w_idx];
                        r_cnt        <= r_cnt + 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (bmem_resp) r_d_resp <= 1'b1;
                end
                ST_DONE: r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

`ifdef BMEM_LINE_ADAPTER_PERF_EN
    logic [31:0] _perf_countRead, _perf_countWrite, _perf_countBusy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            _perf_countRead  <= '0;
            _perf_countWrite <= '0;
            _perf_countBusy  <= '0;
        end else begin
            if (w_done && !r_is_wr && (_perf_countRead != '1))
                _perf_countRead <= _perf_countRead + 32'd1;
            if (w_done && r_is_wr && (_perf_countWrite != '1))
                _perf_countWrite <= _perf_countWrite + 32'd1;
            if ((r_state != ST_IDLE) && (_perf_countBusy != '1))
                _perf_countBusy <= _perf_countBusy + 32'd1;
        end
    end
`endif

    assign i_rdata      = r_i_rdata;
    assign i_resp       = r_i_resp;
    assign d_rdata      = r_d_rdata;
    assign d_resp       = r_d_resp;
    assign bmem_address = r_addr;
    assign bmem_read    = r_bmem_read;
    assign bmem_write   = r_bmem_write;
    assign bmem_wdata   = r_bmem_wdata;

endmodule
